// File: rtl/data_path.sv
// data_path: single-cycle ARM load/store datapath with PC, register file and address ALU
module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  a1,
  input  logic [3:0]  a2,
  input  logic [3:0]  a3,
  input  logic [31:0] wd,
  input  logic [31:0] r15,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);
  logic [31:0] register_file [0:14];
  // r15 is not stored; it reads back as the pipeline-visible PC+8
  always_comb begin
    read_data1 = (a1 == 4'hf) ? r15 : register_file[a1];
    read_data2 = (a2 == 4'hf) ? r15 : register_file[a2];
  end
  // write-back; writes aimed at r15 are dropped so only pc_src moves the PC
  always_ff @(posedge clk)
    if (we && a3 != 4'hf) register_file[a3] <= wd;
endmodule

module data_path (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic        reg_write,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  input  logic [1:0]  alu_ctl,
  output logic [31:0] pc,
  output logic [31:0] write_data,
  output logic [31:0] alu_result
);
  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_pc8;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic        w_unused;
  assign w_pc4 = r_pc + 32'd4;
  assign w_pc8 = r_pc + 32'd8;
  assign w_src_b = {20'd0, instr[11:0]};
  assign w_unused = ^instr[31:20];
  assign pc = r_pc;
  reg_file register_file (
    .clk(clk),
    .we(reg_write),
    .a1(instr[19:16]),
    .a2(instr[15:12]),
    .a3(instr[15:12]),
    .wd(read_data),
    .r15(w_pc8),
    .read_data1(w_src_a),
    .read_data2(write_data)
  );
  // program counter: reset, branch to read_data, or sequential
  always_ff @(posedge clk)
    r_pc <= reset ? 32'd0 : pc_src ? read_data : w_pc4;
  // address ALU: base register combined with zero-extended imm12
  always_comb
    alu_result = (alu_ctl == 2'b00) ? w_src_a + w_src_b :
                 (alu_ctl == 2'b01) ? w_src_a - w_src_b :
                 (alu_ctl == 2'b10) ? w_src_a & w_src_b : w_src_a | w_src_b;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed checks of the load/store datapath
module tb_data_path;
  logic        clk = 0;
  logic        reset = 0;
  logic        pc_src = 0;
  logic        reg_write = 0;
  logic [31:0] instr = 0;
  logic [31:0] read_data = 0;
  logic [1:0]  alu_ctl = 0;
  logic [31:0] pc;
  logic [31:0] write_data;
  logic [31:0] alu_result;
  int total = 0;
  int bad = 0;
  data_path dut (
    .clk(clk),
    .reset(reset),
    .pc_src(pc_src),
    .reg_write(reg_write),
    .instr(instr),
    .read_data(read_data),
    .alu_ctl(alu_ctl),
    .pc(pc),
    .write_data(write_data),
    .alu_result(alu_result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    reset = 1;
    instr = 32'hE59F0000;
    tick();
    check("rst_pc", pc, 32'd0);
    check("rst_r15", dut.register_file.read_data1, 32'd8);
    reset = 0;
    tick(); tick(); tick();
    check("pc_seq", pc, 32'd12);
    instr = 32'hE5901000; read_data = 32'd15; reg_write = 1;
    tick();
    check("ld_r1", dut.register_file.register_file[1], 32'd15);
    instr = 32'hE590B000; read_data = 32'd32;
    tick();
    check("ld_r11", dut.register_file.register_file[11], 32'd32);
    reg_write = 0; read_data = 32'd77;
    instr = 32'hE58B1000; alu_ctl = 2'b00;
    #1;
    check("st_data", write_data, 32'd15);
    check("st_addr", alu_result, 32'd32);
    tick();
    check("st_r1_keep", write_data, 32'd15);
    check("st_r11_keep", dut.register_file.register_file[11], 32'd32);
    instr = 32'hE58B000C;
    alu_ctl = 2'b00; #1; check("alu_add", alu_result, 32'd44);
    alu_ctl = 2'b01; #1; check("alu_sub", alu_result, 32'd20);
    alu_ctl = 2'b10; #1; check("alu_and", alu_result, 32'd0);
    alu_ctl = 2'b11; #1; check("alu_orr", alu_result, 32'd44);
    alu_ctl = 2'b00;
    instr = 32'hE58F0000; read_data = 32'd128; pc_src = 1;
    tick();
    check("br_pc", pc, 32'd128);
    check("br_r15", dut.register_file.read_data1, 32'd136);
    check("br_addr", alu_result, 32'd136);
    pc_src = 0;
    tick();
    check("br_seq", pc, 32'd132);
    instr = 32'hE5901000; read_data = 32'd99; reg_write = 0;
    tick();
    check("guard_r1", write_data, 32'd15);
    instr = 32'hE590F000; read_data = 32'h40; reg_write = 1;
    #1;
    check("wd_r15", write_data, 32'd144);
    tick();
    check("guard_pc", pc, 32'd140);
    check("guard_r1b", dut.register_file.register_file[1], 32'd15);
    instr = 32'hE5911000; read_data = 32'd7;
    #1;
    check("old_read", write_data, 32'd15);
    tick();
    check("new_read", write_data, 32'd7);
    instr = 32'hE5902000; read_data = 32'h55; reset = 1; pc_src = 1;
    tick();
    check("rst_wr_pc", pc, 32'd0);
    check("rst_wr_r2", dut.register_file.register_file[2], 32'h55);
    reset = 0; reg_write = 0;
    instr = 32'hE59F0000; read_data = 32'hFFFFFFFC;
    tick();
    check("wrap_pc", pc, 32'hFFFFFFFC);
    check("wrap_r15", dut.register_file.read_data1, 32'd4);
    pc_src = 0;
    tick();
    check("wrap_pc4", pc, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
